instr_prefetch_queue: RTL and testbench

//  Parametrised instruction fetch unit with a prefetch queue. Owns the fetch PC,

---
 rtl/instr_prefetch_queue.sv | 256 +++++++++++++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
//   Instruction fetch unit with a prefetch queue. It owns the fetch PC and
//   issues one word read at a time to instruction memory (req/gnt/rvalid).
//   Returned words are stored with their addresses in a DEPTH-entry FIFO,
//   and the FIFO feeds decode through a valid/ready interface. A redirect
//   flushes the queue and restarts fetch at a new PC. If a read is still
//   outstanding, its response is marked stale and discarded.
//
// Ports
//   clk            clock, all state changes on posedge
//   rst            asynchronous reset, active low
//   redirect_valid flush the queue and restart fetch at redirect_pc
//   redirect_pc    new fetch PC
//   mem_req        read request to instruction memory
//   mem_addr       read address, held stable while mem_req is waiting for gnt
//   mem_gnt        memory accepted the request this cycle
//   mem_rvalid     read data valid
//   mem_rdata      read data
//   out_valid      queue head valid
//   out_ir         head instruction (NOP_WORD when the queue is empty)
//   out_pc         address of the head instruction
//   out_ready      decode consumes the head this cycle
module instr_prefetch_queue #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 16,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}},
  parameter logic [ADDR_W-1:0]  PC_INC   = ADDR_W'(1),
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(16'h0800)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_ir,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   fetch_pc_r;
  logic [ADDR_W-1:0]   req_addr_r;
  logic                stale_r;
  logic                mem_req_s;

  logic [DATA_W-1:0]   q_ir_r [DEPTH];
  logic [ADDR_W-1:0]   q_pc_r [DEPTH];
  logic [PTR_W:0]      wr_ptr_r;
  logic [PTR_W:0]      rd_ptr_r;
  logic [PTR_W:0]      wr_nxt_s;
  logic [PTR_W:0]      rd_nxt_s;

  logic                empty_s;
  logic                full_s;
  logic                push_s;
  logic                pop_s;
  logic                head_valid_s;
  logic [DATA_W-1:0]   head_ir_s;
  logic [ADDR_W-1:0]   head_pc_s;

  logic                out_valid_r;
  logic [DATA_W-1:0]   out_ir_r;
  logic [ADDR_W-1:0]   out_pc_r;

  // Queue status, and the push/pop qualifiers. A redirect suppresses both.
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
              (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    push_s  = (state_r == ST_WAIT) && mem_rvalid && !stale_r && !redirect_valid;
    pop_s   = !empty_s && out_ready && !redirect_valid;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state. In IDLE no read is in flight, so "not full" means that
  // count plus in-flight is less than DEPTH. A redirect in IDLE starts the
  // request to redirect_pc in the next cycle. The flush leaves room for it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (redirect_valid || !full_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs. The request is decoded only from the state register.
  always_comb begin
    mem_req_s = 1'b0;
    case (state_r)
      ST_REQ:  mem_req_s = 1'b1;
      default: mem_req_s = 1'b0;
    endcase
  end

  assign mem_req  = mem_req_s;
  assign mem_addr = req_addr_r;

  // Fetch PC, latched request address and the stale-response flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_r <= RESET_PC;
      req_addr_r <= RESET_PC;
      stale_r    <= 1'b0;
    end else begin
      // A redirect always wins. A stale grant does not advance the PC.
      if (redirect_valid) begin
        fetch_pc_r <= redirect_pc;
      end else if ((state_r == ST_REQ) && mem_gnt && !stale_r) begin
        fetch_pc_r <= req_addr_r + PC_INC;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end

      // The address is captured only when a new request starts. An
      // un-granted request is never retracted or changed.
      if ((state_r == ST_IDLE) && (state_nxt_s == ST_REQ)) begin
        req_addr_r <= redirect_valid ? redirect_pc : fetch_pc_r;
      end else begin
        req_addr_r <= req_addr_r;
      end

      // A response that returns in the redirect cycle is dropped right away,
      // so that case does not leave the flag set.
      case (state_r)
        ST_REQ: begin
          if (redirect_valid) begin
            stale_r <= 1'b1;
          end else begin
            stale_r <= stale_r;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            stale_r <= 1'b0;
          end else if (redirect_valid) begin
            stale_r <= 1'b1;
          end else begin
            stale_r <= stale_r;
          end
        end
        default: stale_r <= 1'b0;
      endcase
    end
  end

  // Next queue pointers. The flush on redirect overrides push and pop.
  always_comb begin
    wr_nxt_s = wr_ptr_r;
    rd_nxt_s = rd_ptr_r;
    if (redirect_valid) begin
      wr_nxt_s = {(PTR_W+1){1'b0}};
      rd_nxt_s = {(PTR_W+1){1'b0}};
    end else begin
      wr_nxt_s = wr_ptr_r + {{PTR_W{1'b0}}, push_s};
      rd_nxt_s = rd_ptr_r + {{PTR_W{1'b0}}, pop_s};
    end
  end

  // Next head entry. If the head is the word being written this cycle,
  // take it from the write data, because the array is not updated yet.
  always_comb begin
    head_valid_s = (wr_nxt_s != rd_nxt_s);
    head_ir_s    = NOP_WORD;
    head_pc_s    = {ADDR_W{1'b0}};
    if (!head_valid_s) begin
      head_ir_s = NOP_WORD;
      head_pc_s = {ADDR_W{1'b0}};
    end else if (push_s && (rd_nxt_s == wr_ptr_r)) begin
      head_ir_s = mem_rdata;
      head_pc_s = req_addr_r;
    end else begin
      head_ir_s = q_ir_r[rd_nxt_s[PTR_W-1:0]];
      head_pc_s = q_pc_r[rd_nxt_s[PTR_W-1:0]];
    end
  end

  // Queue pointers and storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {(PTR_W+1){1'b0}};
      rd_ptr_r <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        q_ir_r[i] <= NOP_WORD;
        q_pc_r[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      if (push_s) begin
        q_ir_r[wr_ptr_r[PTR_W-1:0]] <= mem_rdata;
        q_pc_r[wr_ptr_r[PTR_W-1:0]] <= req_addr_r;
      end
    end
  end

  // Registered decode-side outputs. They mirror the head entry for the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_ir_r    <= NOP_WORD;
      out_pc_r    <= {ADDR_W{1'b0}};
    end else begin
      out_valid_r <= head_valid_s;
      out_ir_r    <= head_ir_s;
      out_pc_r    <= head_pc_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_ir    = out_ir_r;
  assign out_pc    = out_pc_r;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue
//   Self-checking bench for instr_prefetch_queue. A behavioural memory grants
//   requests after gnt_dly cycles. It returns addr ^ 16'hA5A5 rv_lat cycles
//   after the grant. Each reset release or redirect loads the expected PC
//   sequence into a scoreboard queue. A monitor pops that queue on every
//   consumed output word and compares the word with the DUT.
module tb_instr_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic [15:0] out_ir;
  logic [15:0] out_pc;
  logic        out_ready;

  int          checks_cnt;
  int          errors_cnt;
  int          pop_cnt;
  int          gnt_cnt;
  logic [15:0] last_gnt_addr;
  int          gnt_dly;
  int          rv_lat;
  int          gw;
  int          rvc;
  bit          pend;
  logic [15:0] pend_addr;
  bit          hold_valid;
  logic [15:0] hold_addr;
  logic [15:0] exp_q [$];

  instr_prefetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ir         (out_ir),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Move to 1 time unit after the next falling edge. Drive and check there.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic sb_load(input logic [15:0] start, input int n);
    logic [15:0] a;
    exp_q.delete();
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 16'd1;
    end
  endtask

  // Hold a redirect for the current cycle, then release it.
  task automatic do_redirect(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    sb_load(pc, 64);
    step();
    redirect_valid = 1'b0;
  endtask

  // Behavioural instruction memory. It decides gnt/rvalid on the falling edge.
  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst) begin
        pend       = 1'b0;
        gw         = gnt_dly;
        hold_valid = 1'b0;
      end else if (pend) begin
        if (rvc == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pend_addr ^ 16'hA5A5;
          pend       = 1'b0;
        end else begin
          rvc--;
        end
      end else if (mem_req) begin
        if (hold_valid) check_value("req_addr_hold", 32'(mem_addr), 32'(hold_addr));
        if (gw == 0) begin
          mem_gnt       = 1'b1;
          pend          = 1'b1;
          pend_addr     = mem_addr;
          rvc           = rv_lat - 1;
          gnt_cnt++;
          last_gnt_addr = mem_addr;
          gw            = gnt_dly;
          hold_valid    = 1'b0;
        end else begin
          gw--;
          hold_valid = 1'b1;
          hold_addr  = mem_addr;
        end
      end
    end
  end

  // Scoreboard monitor. It compares every word consumed by decode.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && out_valid && out_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          check_value("sb_extra_word", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_value("out_pc", 32'(out_pc), 32'(e));
          check_value("out_ir", 32'(out_ir), 32'(e ^ 16'hA5A5));
          pop_cnt++;
        end
      end else if (rst && !out_valid) begin
        check_value("empty_ir_nop", 32'(out_ir), 32'h0000_0800);
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int k;
    logic [15:0] a;
    checks_cnt     = 0;
    errors_cnt     = 0;
    pop_cnt        = 0;
    gnt_cnt        = 0;
    last_gnt_addr  = 16'h0000;
    gnt_dly        = 0;
    rv_lat         = 1;
    gw             = 0;
    rvc            = 0;
    pend           = 1'b0;
    hold_valid     = 1'b0;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    out_ready      = 1'b0;
    repeat (3) step();

    // Values while reset is held.
    check_value("rst_mem_req",   32'(mem_req),   32'd0);
    check_value("rst_mem_addr",  32'(mem_addr),  32'h0000);
    check_value("rst_out_valid", 32'(out_valid), 32'd0);
    check_value("rst_out_ir",    32'(out_ir),    32'h0000_0800);
    check_value("rst_out_pc",    32'(out_pc),    32'h0000);

    // Test 1: assert reset while a read is outstanding (WAIT).
    rv_lat = 3;
    rst    = 1'b1;
    sb_load(16'h0000, 64);
    k = 0;
    while (!mem_gnt && k < 20) begin step(); k++; end
    check_value("t1_gnt_seen", 32'(mem_gnt), 32'd1);
    step();
    rst = 1'b0;
    #1;
    check_value("t1_mem_req",   32'(mem_req),   32'd0);
    check_value("t1_out_valid", 32'(out_valid), 32'd0);
    check_value("t1_out_ir",    32'(out_ir),    32'h0000_0800);
    step();
    step();
    rv_lat  = 1;
    gnt_cnt = 0;
    rst     = 1'b1;
    sb_load(16'h0000, 64);
    k = 0;
    while (!mem_gnt && k < 20) begin step(); k++; end
    check_value("t1_gnt_after_rst", 32'(mem_gnt), 32'd1);
    check_value("t1_first_addr", 32'(last_gnt_addr), 32'h0000);

    // Test 2: fill the queue with decode stalled.
    repeat (20) step();
    check_value("t2_gnt_count", 32'(gnt_cnt), 32'd4);
    check_value("t2_last_addr", 32'(last_gnt_addr), 32'h0003);
    check_value("t2_mem_req",   32'(mem_req), 32'd0);
    check_value("t2_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_value("t2_out_pc", 32'(out_pc), 32'h0000);
      check_value("t2_out_ir", 32'(out_ir), 32'h0000_A5A5);
      step();
    end

    // Test 3: drain. Fetch continues in order from 4.
    rv_lat    = 2;
    out_ready = 1'b1;
    p0        = pop_cnt;
    k         = 0;
    while (!(mem_gnt && mem_addr == 16'h0005) && k < 60) begin step(); k++; end
    check_value("t3_gnt5_seen", 32'(mem_gnt && mem_addr == 16'h0005), 32'd1);
    check_value("t3_drained", 32'(pop_cnt - p0 >= 4), 32'd1);

    // Test 4: redirect while the read for address 5 waits for data.
    step();
    do_redirect(16'h0040);
    check_value("t4_flushed", 32'(out_valid), 32'd0);
    k = 0;
    while (!out_valid && k < 20) begin step(); k++; end
    check_value("t4_first_pc", 32'(out_pc), 32'h0040);

    // Test 5: grant wait states, and a redirect in REQ before the grant.
    gnt_dly = 3;
    gw      = 3;
    repeat (20) step();
    k = 0;
    while (!(mem_req && !mem_gnt) && k < 20) begin step(); k++; end
    check_value("t5_req_seen", 32'(mem_req && !mem_gnt), 32'd1);
    a = mem_addr;
    do_redirect(16'h0100);
    check_value("t5_req_held",  32'(mem_req),  32'd1);
    check_value("t5_addr_held", 32'(mem_addr), 32'(a));
    p0 = pop_cnt;
    repeat (60) step();
    check_value("t5_progress", 32'(pop_cnt - p0 >= 4), 32'd1);

    // Test 6: the PC wraps from 16'hFFFF to 16'h0000.
    gnt_dly = 0;
    gw      = 0;
    rv_lat  = 1;
    do_redirect(16'hFFFF);
    p0 = pop_cnt;
    repeat (30) step();
    check_value("t6_progress", 32'(pop_cnt - p0 >= 3), 32'd1);

    out_ready = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
